// File: rtl/out_act_drain.sv
// Output activation drain: walks the PE activation register file in address order,
// converts each accumulator value to output width and streams it over valid/ready.
module out_act_drain #(
  parameter int ACT_WIDTH  = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_ACT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  PE_IDX,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         act_num,
  input  logic [3:0]                  shift,
  input  logic                        relu_en,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic signed [ACT_WIDTH-1:0] rd_data,
  input  logic                        wr_en_mon,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam logic [ADDR_WIDTH:0] MAX_NUM = (ADDR_WIDTH+1)'(NUM_ACT);
  localparam logic signed [ACT_WIDTH-1:0] SAT_HI =
    $signed({{(ACT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACT_WIDTH-1:0] SAT_LO =
    $signed({{(ACT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [ACT_WIDTH-1:0] t);
    if (t > SAT_HI)      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (t < SAT_LO) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                 return t[OUT_WIDTH-1:0];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] convert(
    input logic signed [ACT_WIDTH-1:0] x,
    input logic [3:0]                  sh,
    input logic                        relu);
    logic signed [ACT_WIDTH-1:0] t;
    t = x >>> sh;
    if (relu && (t < 0)) t = '0;
    return saturate(t);
  endfunction

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH:0]         act_num_q, act_num_d;
  logic [ADDR_WIDTH:0]         rd_ptr_q, rd_ptr_d;
  logic [3:0]                  shift_q, shift_d;
  logic                        relu_q, relu_d;
  logic                        inflight_q;
  logic [ADDR_WIDTH-1:0]       inflight_addr_q;
  logic [1:0]                  count_q, count_d;
  logic                        head_q, head_d, tail_q, tail_d;

  logic signed [OUT_WIDTH-1:0] fifo_data_q [2];
  logic [ADDR_WIDTH-1:0]       fifo_addr_q [2];
  logic                        fifo_last_q [2];

  logic                        pop, push;
  logic [2:0]                  occ;
  logic signed [OUT_WIDTH-1:0] conv_p1;
  logic                        last_p1;

  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  assign out_valid = (count_q != 2'd0);
  // Payload is forced to zero when nothing is valid so idle/reset outputs read as 0.
  assign out_data  = out_valid ? fifo_data_q[head_q] : '0;
  assign out_addr  = out_valid ? fifo_addr_q[head_q] : '0;
  assign out_last  = out_valid ? fifo_last_q[head_q] : 1'b0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];

  // Occupancy counts the read still in the register file pipe, so the FIFO never overflows.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q};
  assign rd_en = (state_q == DRAIN) && (rd_ptr_q < act_num_q) &&
                 ((occ - {2'b00, pop}) < 3'd2);

  // Stage p1: read data returns and is converted before entering the FIFO
  assign conv_p1 = convert(rd_data, shift_q, relu_q);
  assign last_p1 = ({1'b0, inflight_addr_q} == (act_num_q - 1'b1));

  always_comb begin
    state_d   = state_q;
    act_num_d = act_num_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    rd_ptr_d  = rd_ptr_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    case (state_q)
      IDLE: if (start) begin
        act_num_d = (act_num > MAX_NUM) ? MAX_NUM : act_num;
        shift_d   = shift;
        relu_d    = relu_en;
        rd_ptr_d  = '0;
        state_d   = (act_num == '0) ? FINISH : DRAIN;
      end
      DRAIN:   if (pop && out_last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push)  tail_d   = ~tail_q;
    if (pop)   head_d   = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      act_num_q  <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_num_q  <= act_num_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= rd_en;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Stage p0 -> p1 address tracking and FIFO storage (datapath, not reset)
  always_ff @(posedge clk) begin
    if (rd_en) inflight_addr_q <= rd_addr;
    if (push) begin
      fifo_data_q[tail_q] <= conv_p1;
      fifo_addr_q[tail_q] <= inflight_addr_q;
      fifo_last_q[tail_q] <= last_p1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && wr_en_mon && busy)
      $display("[WARNING]: PE[%0d] drain/write hazard @ %0t", PE_IDX, $time);
  end
`endif

endmodule

// File: tb/tb_out_act_drain.sv
// Bench for out_act_drain: conversion vector table, cycle-exact hand sequences and
// randomized drains checked against an arithmetic reference model.
module tb_out_act_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  pe_idx = 6'd3;
  logic        start = 1'b0;
  logic [6:0]  act_num = '0;
  logic [3:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [23:0] rd_data = '0;
  logic        wr_en_mon = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [5:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  out_act_drain dut (
    .clk(clk), .rst(rst), .PE_IDX(pe_idx), .start(start), .act_num(act_num),
    .shift(shift), .relu_en(relu_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en_mon(wr_en_mon), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [64];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 24'($urandom);

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference conversion: floor division by 2^s, ReLU, then clamp to 16-bit range.
  function automatic logic [15:0] ref_conv(logic [23:0] raw, int s, bit r);
    int x, d, t;
    x = int'($signed(raw));
    d = 1 << s;
    if (x >= 0) t = x / d;
    else        t = -((-x + d - 1) / d);
    if (r && t < 0) t = 0;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return 16'(t);
  endfunction

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  addr;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  // Stream monitor: order/content, stall stability, read occupancy bound.
  logic        mon_pop;
  int          outstanding = 0;
  int          pop_cnt = 0;
  logic        stall_q = 1'b0;
  logic [22:0] held_q = '0;
  assign mon_pop = out_valid & out_ready;

  always @(negedge clk) begin
    if (rst) begin
      outstanding <= 0;
      stall_q     <= 1'b0;
    end else begin
      if (stall_q)
        check("stall_hold", 32'({out_valid, out_data, out_addr, out_last}), 32'({1'b1, held_q}));
      if (rd_en)
        check("rd_occupancy", 32'((outstanding - int'(mon_pop)) >= 2), 32'd0);
      if (mon_pop) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'(out_addr), 32'hFFFF);
        else begin
          check("stream", 32'({out_data, out_addr, out_last}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      pop_cnt     <= pop_cnt + int'(mon_pop);
      stall_q     <= out_valid & ~out_ready;
      held_q      <= {out_data, out_addr, out_last};
      outstanding <= outstanding + int'(rd_en) - int'(mon_pop);
    end
  end

  int          busy_mask, valid_mask, done_mask, rd_cnt, pop_base;
  logic [5:0]  max_addr;
  logic [15:0] first_out;

  task automatic run_drain(input int n, input int s, input bit r, input int mode,
                           input int inject_cyc, input int hazard_cyc, output int done_cyc);
    int cyc;
    bit seen, got_first;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: ref_conv(mem[i], s, r), addr: 6'(i), last: (i == n - 1)});
    busy_mask = 0; valid_mask = 0; done_mask = 0; rd_cnt = 0; max_addr = '0;
    first_out = '0; got_first = 0; done_cyc = -1; pop_base = pop_cnt;
    @(posedge clk); #1;
    start = 1'b1; act_num = 7'(n); shift = 4'(s); relu_en = r;
    @(posedge clk); #1;
    start = 1'b0; act_num = 7'($urandom_range(0, 64)); shift = 4'($urandom); relu_en = ~r;
    cyc = 1; seen = 0;
    while (!seen && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc - 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start     = (cyc == inject_cyc);
      wr_en_mon = (cyc == hazard_cyc);
      @(negedge clk);
      if (cyc < 32) begin
        busy_mask[cyc]  = busy;
        valid_mask[cyc] = out_valid;
        done_mask[cyc]  = done;
      end
      if (out_valid && !got_first) begin first_out = out_data; got_first = 1; end
      if (rd_en) begin
        rd_cnt++;
        if (rd_addr > max_addr) max_addr = rd_addr;
      end
      if (done) begin seen = 1; done_cyc = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; wr_en_mon = 1'b0; out_ready = 1'b1;
    check("drain_done_seen", 32'(seen), 32'd1);
    check("drain_all_popped", 32'(exp_q.size()), 32'd0);
    if (!seen) exp_q.delete();
  endtask

  typedef struct {
    logic [23:0] data;
    int          sh;
    bit          relu;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int dc;
    bit saw_done;
    tbl[0]  = '{24'h7FFFFF, 4,  1'b1, 16'h7FFF};
    tbl[1]  = '{24'hFFFF00, 4,  1'b1, 16'h0000};
    tbl[2]  = '{24'h000800, 4,  1'b1, 16'h0080};
    tbl[3]  = '{24'h800000, 0,  1'b0, 16'h8000};
    tbl[4]  = '{24'hFFFF00, 4,  1'b0, 16'hFFF0};
    tbl[5]  = '{24'h123456, 8,  1'b0, 16'h1234};
    tbl[6]  = '{24'h008000, 0,  1'b0, 16'h7FFF};
    tbl[7]  = '{24'hFF7FFF, 0,  1'b0, 16'h8000};
    tbl[8]  = '{24'hFF8000, 0,  1'b0, 16'h8000};
    tbl[9]  = '{24'h007FFF, 0,  1'b1, 16'h7FFF};
    tbl[10] = '{24'h800000, 15, 1'b0, 16'hFF00};
    tbl[11] = '{24'hFFFFFF, 15, 1'b0, 16'hFFFF};
    tbl[12] = '{24'h800000, 15, 1'b1, 16'h0000};
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({rd_en, rd_addr, out_valid, out_data, out_addr, out_last, busy, done}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Basic drain with exact cycle timing
    mem[0] = 24'h000005; mem[1] = 24'hFFFFFE; mem[2] = 24'h000100; mem[3] = 24'h001234;
    run_drain(4, 0, 1'b0, 0, 0, 0, dc);
    check("basic_done_cycle", 32'(dc), 32'd7);
    check("basic_valid_cycles", 32'(valid_mask), 32'h78);
    check("basic_busy_cycles", 32'(busy_mask), 32'hFE);
    check("basic_done_pulse", 32'(done_mask), 32'h80);
    check("basic_first_data", 32'(first_out), 32'h0005);

    // Conversion vector table, one element per drain
    for (int i = 0; i < 13; i++) begin
      mem[0] = tbl[i].data;
      run_drain(1, tbl[i].sh, tbl[i].relu, 0, 0, 0, dc);
      check($sformatf("conv%0d", i), 32'(first_out), 32'(tbl[i].exp));
    end

    // Backpressure with 1,0,0 ready pattern
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    run_drain(8, 3, 1'b0, 1, 0, 0, dc);
    check("bp_pop_count", 32'(pop_cnt - pop_base), 32'd8);
    check("bp_read_count", 32'(rd_cnt), 32'd8);

    // Zero-length drain
    run_drain(0, 0, 1'b0, 0, 0, 0, dc);
    check("zero_done_cycle", 32'(dc), 32'd1);
    check("zero_no_reads", 32'(rd_cnt), 32'd0);
    check("zero_busy", 32'(busy_mask), 32'h2);

    // Full-depth drain
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    run_drain(64, 2, 1'b1, 0, 0, 0, dc);
    check("full_max_addr", 32'(max_addr), 32'd63);
    check("full_read_count", 32'(rd_cnt), 32'd64);
    check("full_done_cycle", 32'(dc), 32'd67);

    // Start during drain is ignored
    for (int i = 0; i < 6; i++) mem[i] = 24'hF00000 | 24'($urandom_range(0, 65535));
    run_drain(6, 2, 1'b0, 1, 3, 0, dc);
    check("ignored_start_pops", 32'(pop_cnt - pop_base), 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ignored_start_idle", 32'({busy, out_valid}), 32'd0);

    // Hazard monitor does not disturb the stream
    for (int i = 0; i < 5; i++) mem[i] = 24'($urandom);
    run_drain(5, 1, 1'b0, 0, 0, 2, dc);
    check("hazard_done_cycle", 32'(dc), 32'd8);

    // Reset mid-drain
    for (int i = 0; i < 10; i++) mem[i] = 24'($urandom);
    @(posedge clk); #1;
    start = 1'b1; act_num = 7'd10; shift = 4'd0; relu_en = 1'b0;
    for (int i = 0; i < 10; i++)
      exp_q.push_back('{data: ref_conv(mem[i], 0, 1'b0), addr: 6'(i), last: (i == 9)});
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; exp_q.delete();
    #1;
    check("midrst_outputs", 32'({rd_en, rd_addr, out_valid, out_data, out_addr, out_last, busy, done}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    saw_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_drain(3, 0, 1'b0, 0, 0, 0, dc);
    check("midrst_redrain_cycle", 32'(dc), 32'd6);

    // Randomized drains under random backpressure
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++)
        mem[i] = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($signed(16'($urandom)));
      run_drain(n, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 2, 0, 0, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
